tmds_decoder: RTL and testbench
===============================

TMDS_DECODER -- requirements
Module: tmds_decoder

Interface
REQ-001 Parameter LOCK_COUNT, default 16: consecutive control tokens needed to declare lock.
REQ-002 Parameter SEARCH_WINDOW, default 1024: cycles without any control token before the offset advances or lock drops.
REQ-003 Port clkp  input  1  pixel clock; all logic is synchronous to rising clkp.
REQ-004 Port resetn  input  1  reset, asynchronous, active-low.
REQ-005 Port sym_in  input  10  raw deserialized channel word, one per clkp; bit 0 is earliest transmitted; word boundary arbitrary.
REQ-006 Port data  output  8  decoded pixel byte.
REQ-007 Port c  output  2  decoded control bits {c1,c0}.
REQ-008 Port de  output  1  1 = data symbol decoded this cycle.
REQ-009 Port locked  output  1  word alignment established.
REQ-010 Port offset  output  4  current bit-slip offset, 0..9.

Function
REQ-011 The block SHALL register sym_in into sym_d1 every cycle and form hist = {sym_in, sym_d1} (20 bits).
REQ-012 The aligned word SHALL be hist[offset+9:offset], registered each cycle.
REQ-013 Decoding SHALL take the registered aligned word w and register its results onto data/c/de, so a symbol sampled at edge N (offset 0) appears on outputs after edge N+2.
REQ-014 Control tokens, bits 9..0: 1101010100 -> c=00; 0010101011 -> c=01; 0101010100 -> c=10; 1010101011 -> c=11; on a token: de=0, data=0x00.
REQ-015 Any other word SHALL decode as data: q = w[9] ? ~w[7:0] : w[7:0]; d0 = q0; di = w[8] ? q[i]^q[i-1] : ~(q[i]^q[i-1]) for i=1..7; de=1; c holds last value.
REQ-016 While locked=0, outputs SHALL be forced to de=0, data=0x00, c=00.
REQ-017 FSM states: SEARCH (reset state), LOCKED.
REQ-018 SEARCH: run counter increments on each control token and clears on each data word; reaching LOCK_COUNT -> LOCKED, locked=1 on the next edge.
REQ-019 SEARCH: window counter counts cycles since last control token or offset change; reaching SEARCH_WINDOW -> offset advances by 1 (9 wraps to 0); run and window counters clear.
REQ-020 LOCKED: window counter clears on every control token; reaching SEARCH_WINDOW -> SEARCH, locked=0, offset advances by 1, counters clear.
REQ-021 On an offset change, the two pipeline words in flight SHALL NOT count toward the run counter (2-cycle blanking of token detection).
REQ-022 Counters SHALL saturate or clear as stated, never wrap silently; the run counter width covers LOCK_COUNT, the window counter width covers SEARCH_WINDOW.
REQ-023 Token and window events in the same cycle: the token wins (window clears).

Reset
REQ-024 resetn low SHALL immediately set state=SEARCH, offset=0, all counters=0, sym_d1=0, aligned word=0, data=0x00, c=00, de=0, locked=0, including mid-lock.
REQ-025 After resetn rises, operation SHALL start on the first clkp edge with no extra sync cycles inside the block.

Structure
REQ-026 A shared package tmds_pkg SHALL hold the four control-token constants, the FSM state enum, and the symbol width (10) and data width (8) constants; the existing encoder shares these.
REQ-027 The 10b-to-8b/control decode SHALL be a combinational sub-module tmds_sym_decode; alignment, FSM and registers stay in tmds_decoder.

Verification
REQ-028 Reset: resetn=0 mid-stream -> data=0x00, c=00, de=0, locked=0, offset=0 with no clkp edge required.
REQ-029 Bit-slip: encoder stream shifted by 3 bits, 200 blanking tokens c=00 per line of 800 -> locked=1 and offset=3 within 10*SEARCH_WINDOW+LOCK_COUNT cycles.
REQ-030 Data: locked stream of encoded 0x00..0xFF -> data equals the input byte, de=1, exactly 2 edges after sampling.
REQ-031 Control: tokens c=00, 01, 10, 11 in sequence -> c follows with de=0, data=0x00.
REQ-032 Loss: while locked, send 1024 consecutive data words -> locked=0 and offset advances by 1 on the 1024th cycle; 1023 words followed by a token keep locked=1.
REQ-033 Wrap: lock found at offset 9, then forced loss -> offset becomes 0.

Source files
------------

// File: rtl/tmds_pkg.sv
// ============================================================
// tmds_pkg : TMDS symbol constants and decoder FSM state type
// Rev 1.0
// ============================================================
`default_nettype none

package tmds_pkg;

  localparam int C_SYM_W  = 10;
  localparam int C_DATA_W = 8;

  localparam logic [C_SYM_W-1:0] C_TOK_C00 = 10'b1101010100;
  localparam logic [C_SYM_W-1:0] C_TOK_C01 = 10'b0010101011;
  localparam logic [C_SYM_W-1:0] C_TOK_C10 = 10'b0101010100;
  localparam logic [C_SYM_W-1:0] C_TOK_C11 = 10'b1010101011;

  typedef enum logic [0:0] {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } tmds_state_e;

endpackage

`default_nettype wire

// File: rtl/tmds_sym_decode.sv
// ============================================================
// tmds_sym_decode : combinational 10b symbol to 8b data / control decode
// Rev 1.0
// ============================================================
`default_nettype none

module tmds_sym_decode
  import tmds_pkg::*;
(
  input  logic [C_SYM_W-1:0]  i_word,
  output logic                o_is_ctrl,
  output logic [1:0]          o_ctrl,
  output logic [C_DATA_W-1:0] o_data
);

  logic [C_DATA_W-1:0] w_q;

  always_comb begin
    o_is_ctrl = 1'b1;
    o_ctrl    = 2'b00;
    case (i_word)
      C_TOK_C00: o_ctrl = 2'b00;
      C_TOK_C01: o_ctrl = 2'b01;
      C_TOK_C10: o_ctrl = 2'b10;
      C_TOK_C11: o_ctrl = 2'b11;
      default:   o_is_ctrl = 1'b0;
    endcase
  end

  // Bit 9 flags an inverted payload, bit 8 selects XOR versus XNOR chaining.
  assign w_q = i_word[9] ? ~i_word[7:0] : i_word[7:0];

  always_comb begin
    o_data    = '0;
    o_data[0] = w_q[0];
    for (int i = 1; i < C_DATA_W; i++) begin
      o_data[i] = i_word[8] ? (w_q[i] ^ w_q[i-1]) : ~(w_q[i] ^ w_q[i-1]);
    end
  end

endmodule

`default_nettype wire

// File: rtl/tmds_decoder.sv
// ============================================================
// tmds_decoder : TMDS channel word aligner, lock FSM and symbol decoder
// Rev 1.0
// ============================================================
`default_nettype none

module tmds_decoder
  import tmds_pkg::*;
#(
  parameter int LOCK_COUNT    = 16,
  parameter int SEARCH_WINDOW = 1024
) (
  input  logic                clkp,
  input  logic                resetn,
  input  logic [C_SYM_W-1:0]  sym_in,
  output logic [C_DATA_W-1:0] data,
  output logic [1:0]          c,
  output logic                de,
  output logic                locked,
  output logic [3:0]          offset
);

  localparam int C_RUN_W = $clog2(LOCK_COUNT + 1);
  localparam int C_WIN_W = $clog2(SEARCH_WINDOW + 1);
  localparam logic [C_RUN_W-1:0] C_RUN_LAST = C_RUN_W'(LOCK_COUNT - 1);
  localparam logic [C_WIN_W-1:0] C_WIN_LAST = C_WIN_W'(SEARCH_WINDOW - 1);

  tmds_state_e         r_state;
  logic [C_SYM_W-1:0]  r_sym_d1;
  logic [C_SYM_W-1:0]  r_word;
  logic [C_RUN_W-1:0]  r_run;
  logic [C_WIN_W-1:0]  r_win;
  logic [1:0]          r_blank;
  logic [3:0]          r_offset;
  logic [C_DATA_W-1:0] r_data;
  logic [1:0]          r_c;
  logic                r_de;

  logic [2*C_SYM_W-1:0] w_hist;
  logic [C_SYM_W-1:0]   w_aligned;
  logic                 w_unused_msb;
  logic                 w_is_ctrl;
  logic [1:0]           w_ctrl;
  logic [C_DATA_W-1:0]  w_dec;
  logic                 w_tok;
  logic                 w_dat;
  logic                 w_win_hit;
  logic                 w_lock_hit;
  logic                 w_next_locked;
  logic [3:0]           w_next_off;

  assign w_hist       = {sym_in, r_sym_d1};
  // Offsets stop at 9, so the newest bit of the history is never selected.
  assign w_unused_msb = w_hist[2*C_SYM_W-1];

  always_comb begin
    w_aligned = w_hist[C_SYM_W-1:0];
    for (int k = 1; k < C_SYM_W; k++) begin
      if (r_offset == 4'(k)) begin
        w_aligned = w_hist[k +: C_SYM_W];
      end
    end
  end

  tmds_sym_decode u_sym_decode (
    .i_word    (r_word),
    .o_is_ctrl (w_is_ctrl),
    .o_ctrl    (w_ctrl),
    .o_data    (w_dec)
  );

  // Words straddling an offset change are neither tokens nor data for the run count.
  assign w_tok         = w_is_ctrl && (r_blank == 2'd0);
  assign w_dat         = !w_is_ctrl && (r_blank == 2'd0);
  assign w_win_hit     = !w_tok && (r_win == C_WIN_LAST);
  assign w_lock_hit    = (r_state == ST_SEARCH) && w_tok && (r_run == C_RUN_LAST);
  assign w_next_locked = (r_state == ST_LOCKED) ? !w_win_hit : w_lock_hit;
  assign w_next_off    = (r_offset == 4'd9) ? 4'd0 : r_offset + 4'd1;

  always_ff @(posedge clkp or negedge resetn) begin
    if (!resetn) begin
      r_state  <= ST_SEARCH;
      r_sym_d1 <= '0;
      r_word   <= '0;
      r_run    <= '0;
      r_win    <= '0;
      r_blank  <= 2'd0;
      r_offset <= 4'd0;
      r_data   <= '0;
      r_c      <= 2'b00;
      r_de     <= 1'b0;
    end else begin
      r_sym_d1 <= sym_in;
      r_word   <= w_aligned;
      if (r_blank != 2'd0) begin
        r_blank <= r_blank - 2'd1;
      end

      case (r_state)
        ST_SEARCH: begin
          if (w_lock_hit) begin
            r_state <= ST_LOCKED;
            r_run   <= '0;
            r_win   <= '0;
          end else if (w_tok) begin
            r_run <= r_run + 1'b1;
            r_win <= '0;
          end else if (w_win_hit) begin
            r_offset <= w_next_off;
            r_run    <= '0;
            r_win    <= '0;
            r_blank  <= 2'd2;
          end else begin
            if (w_dat) begin
              r_run <= '0;
            end
            r_win <= r_win + 1'b1;
          end
        end
        ST_LOCKED: begin
          if (w_tok) begin
            r_win <= '0;
          end else if (w_win_hit) begin
            r_state  <= ST_SEARCH;
            r_offset <= w_next_off;
            r_run    <= '0;
            r_win    <= '0;
            r_blank  <= 2'd2;
          end else begin
            r_win <= r_win + 1'b1;
          end
        end
        default: r_state <= ST_SEARCH;
      endcase

      // Gate on the next lock state so outputs are blank whenever locked reads 0.
      if (w_next_locked) begin
        r_de   <= !w_is_ctrl;
        r_data <= w_is_ctrl ? '0 : w_dec;
        if (w_is_ctrl) begin
          r_c <= w_ctrl;
        end
      end else begin
        r_de   <= 1'b0;
        r_data <= '0;
        r_c    <= 2'b00;
      end
    end
  end

  assign data   = r_data;
  assign c      = r_c;
  assign de     = r_de;
  assign locked = (r_state == ST_LOCKED);
  assign offset = r_offset;

endmodule

`default_nettype wire

// File: tb/tb_tmds_decoder.sv
// ============================================================
// tb_tmds_decoder : scoreboard and table driven bench for tmds_decoder
// Rev 1.0
// ============================================================
`default_nettype none

module tb_tmds_decoder;
  import tmds_pkg::*;

  logic        clkp;
  logic        resetn;
  logic [9:0]  sym_in;
  logic [7:0]  data;
  logic [1:0]  c;
  logic        de;
  logic        locked;
  logic [3:0]  offset;

  tmds_decoder #(.LOCK_COUNT(16), .SEARCH_WINDOW(1024)) dut (
    .clkp   (clkp),
    .resetn (resetn),
    .sym_in (sym_in),
    .data   (data),
    .c      (c),
    .de     (de),
    .locked (locked),
    .offset (offset)
  );

  initial clkp = 1'b0;
  always #5 clkp = ~clkp;

  typedef struct packed {
    logic       chk;
    logic [7:0] d;
    logic [1:0] c;
    logic       de;
    logic       lk;
    logic [3:0] off;
  } exp_t;

  typedef struct {
    logic       is_tok;
    logic [7:0] val;
    logic       inv;
    logic [7:0] ed;
    logic [1:0] ec;
    logic       ede;
  } vec_t;

  exp_t       sbq[$];
  vec_t       tbl[12];
  int         n_chk = 0;
  int         n_err = 0;
  int         slip = 0;
  logic [9:0] prev_sym = '0;
  logic [1:0] m_c = 2'b00;

  function automatic logic [9:0] enc(input logic [7:0] d, input logic inv);
    logic [8:0] qm;
    int n1;
    n1 = $countones(d);
    qm[0] = d[0];
    if (n1 > 4 || (n1 == 4 && !d[0])) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
      qm[8] = 1'b1;
    end
    return inv ? {1'b1, qm[8], ~qm[7:0]} : {1'b0, qm};
  endfunction

  function automatic logic [9:0] tok(input logic [1:0] cc);
    case (cc)
      2'b00:   return C_TOK_C00;
      2'b01:   return C_TOK_C01;
      2'b10:   return C_TOK_C10;
      default: return C_TOK_C11;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Drive one channel symbol, bit-slipped by 'slip', and retire the entry two edges old.
  task automatic send(input logic [9:0] s, input exp_t e);
    logic [19:0] pair;
    exp_t x;
    @(negedge clkp);
    pair = {s, prev_sym};
    pair = pair >> (10 - slip);
    sym_in = pair[9:0];
    prev_sym = s;
    sbq.push_back(e);
    @(posedge clkp);
    #1;
    if (sbq.size() == 3) begin
      x = sbq.pop_front();
      if (x.chk) check("pipe {data,c,de,locked,offset}", {data, c, de, locked, offset},
                       {x.d, x.c, x.de, x.lk, x.off});
    end
  endtask

  task automatic send_tok(input logic [1:0] cc, input logic lk, input logic [3:0] off, input logic chk);
    exp_t e;
    e.chk = chk; e.d = 8'h00; e.de = 1'b0; e.lk = lk; e.off = off;
    e.c = lk ? cc : 2'b00;
    m_c = lk ? cc : 2'b00;
    send(tok(cc), e);
  endtask

  task automatic send_dat(input logic [7:0] b, input logic inv, input logic lk, input logic [3:0] off,
                          input logic chk);
    exp_t e;
    e.chk = chk; e.lk = lk; e.off = off; e.de = lk;
    e.d = lk ? b : 8'h00;
    e.c = lk ? m_c : 2'b00;
    if (!lk) m_c = 2'b00;
    send(enc(b, inv), e);
  endtask

  task automatic reset_dut(input string nm);
    @(negedge clkp);
    #1;
    resetn = 1'b0;
    sym_in = '0;
    #1;
    check({nm, "_data"}, data, 8'h00);
    check({nm, "_c"}, c, 2'b00);
    check({nm, "_de"}, de, 1'b0);
    check({nm, "_locked"}, locked, 1'b0);
    check({nm, "_offset"}, offset, 4'd0);
    sbq.delete();
    m_c = 2'b00;
    prev_sym = '0;
    slip = 0;
    @(negedge clkp);
    resetn = 1'b1;
  endtask

  task automatic lock_offset0();
    for (int j = 1; j <= 20; j++) send_tok(2'b00, (j >= 16), 4'd0, 1'b1);
  endtask

  task automatic acquire(input int sl, input string nm, input logic [3:0] want);
    int n;
    slip = sl;
    n = 0;
    while (!locked && n < 10 * 1024 + 16) begin
      if ((n % 800) < 200) send_tok(2'b00, 1'b0, 4'd0, 1'b0);
      else send_dat(8'h00, 1'b0, 1'b0, 4'd0, 1'b0);
      n++;
    end
    check({nm, "_locked_within_budget"}, locked, 1'b1);
    check({nm, "_offset"}, offset, want);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b1, 8'h01, 1'b0, 8'h00, 2'b01, 1'b0};
    tbl[1]  = '{1'b0, 8'h00, 1'b0, 8'h00, 2'b01, 1'b1};
    tbl[2]  = '{1'b0, 8'hFF, 1'b1, 8'hFF, 2'b01, 1'b1};
    tbl[3]  = '{1'b1, 8'h02, 1'b0, 8'h00, 2'b10, 1'b0};
    tbl[4]  = '{1'b0, 8'h55, 1'b0, 8'h55, 2'b10, 1'b1};
    tbl[5]  = '{1'b0, 8'hAA, 1'b1, 8'hAA, 2'b10, 1'b1};
    tbl[6]  = '{1'b1, 8'h03, 1'b0, 8'h00, 2'b11, 1'b0};
    tbl[7]  = '{1'b0, 8'h0F, 1'b0, 8'h0F, 2'b11, 1'b1};
    tbl[8]  = '{1'b1, 8'h00, 1'b0, 8'h00, 2'b00, 1'b0};
    tbl[9]  = '{1'b0, 8'h80, 1'b1, 8'h80, 2'b00, 1'b1};
    tbl[10] = '{1'b1, 8'h01, 1'b0, 8'h00, 2'b01, 1'b0};
    tbl[11] = '{1'b0, 8'h3C, 1'b0, 8'h3C, 2'b01, 1'b1};

    resetn = 1'b0;
    sym_in = '0;
    repeat (3) @(posedge clkp);
    reset_dut("reset_init");

    // Lock at offset 0: the 16th token flips locked.
    lock_offset0();

    foreach (tbl[i]) begin
      exp_t e;
      e.chk = 1'b1; e.lk = 1'b1; e.off = 4'd0;
      e.d = tbl[i].ed; e.c = tbl[i].ec; e.de = tbl[i].ede;
      if (tbl[i].is_tok) send(tok(tbl[i].val[1:0]), e);
      else send(enc(tbl[i].val, tbl[i].inv), e);
      m_c = tbl[i].ec;
    end

    for (int b = 0; b < 256; b++) send_dat(8'(b), 1'($urandom_range(0, 1)), 1'b1, 4'd0, 1'b1);

    reset_dut("reset_midlock");

    // Loss boundary: 1023 data words hold lock, the 1024th drops it.
    lock_offset0();
    for (int k = 1; k <= 1023; k++) send_dat(8'(k), 1'($urandom_range(0, 1)), 1'b1, 4'd0, 1'b1);
    for (int k = 0; k < 4; k++) send_tok(2'b01, 1'b1, 4'd0, 1'b1);
    for (int k = 1; k <= 1024; k++) send_dat(8'(k * 3), 1'b0, (k < 1024), (k < 1024) ? 4'd0 : 4'd1, 1'b1);
    for (int k = 0; k < 4; k++) send_dat(8'h77, 1'b0, 1'b0, 4'd1, 1'b1);

    reset_dut("reset_after_loss");

    acquire(3, "slip3", 4'd3);
    reset_dut("reset_slip3");

    acquire(9, "slip9", 4'd9);
    for (int k = 0; k < 1020; k++) send_dat(8'h00, 1'b0, 1'b0, 4'd0, 1'b0);
    check("wrap_hold_locked", locked, 1'b1);
    check("wrap_hold_offset", offset, 4'd9);
    for (int k = 0; k < 10; k++) send_dat(8'h00, 1'b0, 1'b0, 4'd0, 1'b0);
    check("wrap_lost_locked", locked, 1'b0);
    check("wrap_offset", offset, 4'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
